register_file_sb: RTL

REGISTER_FILE_SB -- requirements
Module: register_file_sb

---
 rtl/register_file_sb.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/register_file_sb.sv
// -----------------------------------------------------------------------------
// register_file_sb
//
// Register file with a scoreboard of pending writes and a post-reset scrub.
// After reset the FSM walks every register and writes zero into it; only then
// does Ready rise and normal reads, writes and reservations take effect.
//
// Ports
//   clk        : single clock, all state updates on its rising edge
//   reset      : asynchronous, active-high reset
//   rs1, rs2   : read addresses; ReadData1/ReadData2 follow one cycle later
//   rd         : write address
//   WriteData  : write data
//   RegWrite   : write enable (also clears the busy bit of rd)
//   Reserve    : scoreboard reserve strobe (sets the busy bit of ResRd)
//   ResRd      : register to reserve
//   ReadData1  : registered read data, port 1
//   ReadData2  : registered read data, port 2
//   Busy1      : pending-write flag for rs1 (combinational)
//   Busy2      : pending-write flag for rs2 (combinational)
//   Ready      : high once the scrub has finished; this is the FSM state
//
// Scoreboard protocol: Reserve marks a register as having a write in flight;
// the write that eventually arrives with RegWrite clears it. A set and a clear
// of the same register in one cycle leave it set. A register being written in
// the current cycle reports not-busy on Busy1/Busy2, since the bypass already
// delivers the new value to the reader.
// -----------------------------------------------------------------------------
module register_file_sb #(
    parameter int XLEN = 64,
    parameter int NREG = 32,
    localparam int AW  = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    input  logic [AW-1:0]   rd,
    input  logic [XLEN-1:0] WriteData,
    input  logic            RegWrite,
    input  logic            Reserve,
    input  logic [AW-1:0]   ResRd,
    output logic [XLEN-1:0] ReadData1,
    output logic [XLEN-1:0] ReadData2,
    output logic            Busy1,
    output logic            Busy2,
    output logic            Ready
);

    typedef enum logic {
        SCRUB = 1'b0,
        READY = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     cnt_q, cnt_d;
    logic [NREG-1:0]   busy_q, busy_d;
    logic [XLEN-1:0]   rd1_q, rd1_d;
    logic [XLEN-1:0]   rd2_q, rd2_d;
    logic [XLEN-1:0]   mem [NREG];

    logic              is_ready;
    logic              we;

    assign is_ready = (state_q == READY);
    // Writes to register 0 and writes during the scrub are dropped.
    assign we       = is_ready && RegWrite && (rd != '0);

    // Next-state logic for the scrub FSM.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == SCRUB) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == AW'(NREG - 1)) begin
                state_d = READY;
            end
        end
    end

    // Scoreboard update: clear on writeback first, then set on reserve so a
    // same-cycle set wins. Bit 0 is forced low because x0 is never pending.
    always_comb begin
        busy_d = busy_q;
        if (is_ready) begin
            if (we) begin
                busy_d[rd] = 1'b0;
            end
            if (Reserve && (ResRd != '0)) begin
                busy_d[ResRd] = 1'b1;
            end
        end
        busy_d[0] = 1'b0;
    end

    // Read data with write-to-read bypass; address 0 always returns zero.
    always_comb begin
        rd1_d = '0;
        rd2_d = '0;
        if (is_ready) begin
            if (rs1 != '0) begin
                rd1_d = (we && (rd == rs1)) ? WriteData : mem[rs1];
            end
            if (rs2 != '0) begin
                rd2_d = (we && (rd == rs2)) ? WriteData : mem[rs2];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= SCRUB;
            cnt_q   <= '0;
            busy_q  <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
        end
    end

    // Storage has no reset; the scrub is what clears it, so a reset at any
    // point leaves stale data only until the scrub overwrites it.
    always_ff @(posedge clk) begin
        if (state_q == SCRUB) begin
            mem[cnt_q] <= '0;
        end else if (we) begin
            mem[rd] <= WriteData;
        end
    end

    assign ReadData1 = rd1_q;
    assign ReadData2 = rd2_q;
    assign Ready     = is_ready;
    assign Busy1     = busy_q[rs1] && !(RegWrite && (rd == rs1));
    assign Busy2     = busy_q[rs2] && !(RegWrite && (rd == rs2));

endmodule
